rotary_encoder_array: RTL
=========================

# rotary_encoder_array

Parametrised multi-channel quadrature decoder for the front-panel rotary encoders. Each channel synchronises and debounces its raw A/B pins. It decodes steps in 1x mode (A rising edge only) or 4x mode (every Gray-code transition) and keeps a signed position count per channel. It sits between the panel I/O pins and the control logic. The control logic consumes either the per-step pulses or the accumulated counts.

## Interface
- `CHANNELS`, 2: number of independent encoders.
- `SYNC_STAGES`, 2: synchroniser flops per input bit, minimum 2.
- `DEBOUNCE_CYCLES`, 1000: consecutive stable cycles required before a level is accepted; 0 bypasses debounce.
- `COUNT_WIDTH`, 16: width of each signed position counter.
- `MODE`, 0: 0 = 1x decode, 1 = 4x decode.
- `SATURATE`, 1: 1 = counter clamps at its limits, 0 = counter wraps.

Ports:
- `i_clk` in 1: the single clock.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_a` in CHANNELS: raw encoder A pins, asynchronous.
- `i_b` in CHANNELS: raw encoder B pins, asynchronous.
- `i_clear` in CHANNELS: per-channel synchronous clear of the count and the error flag.
- `o_up` in CHANNELS, output: 1-cycle pulse per up step.
- `o_down` out CHANNELS: 1-cycle pulse per down step.
- `o_count` out CHANNELS*COUNT_WIDTH: two's-complement counts; channel n occupies bits [n*COUNT_WIDTH +: COUNT_WIDTH].
- `o_error` out CHANNELS: sticky flag for an illegal transition (4x mode only).

## Operation
- **Synchroniser:** SYNC_STAGES flops per bit, not reset.
- **Debounce:** per bit, a counter runs while the synchronised level differs from the accepted level. When it reaches DEBOUNCE_CYCLES, the accepted level is updated. Any return to the accepted level zeroes the counter.
- **Reset:** while `i_rst`=1, the accepted levels load directly from the last synchroniser stage and debounce counters zero. No step is decoded. `i_rst` must be held for at least SYNC_STAGES cycles.
- **Accepted state:** {A,B}. Up sequence is 00→10→11→01→00; down is the reverse.
- **1x mode:** step only when accepted A goes 0→1. B=0 gives up; B=1 gives down. No other transition counts, and `o_error` stays 0.
- **4x mode:** every single-bit change gives one step in the direction of the sequence above. A simultaneous change of both bits gives no step and sets `o_error`.
- **Count update:** +1 per up step, −1 per down step.
  - SATURATE=1: holds at 2^(COUNT_WIDTH−1)−1 and at −2^(COUNT_WIDTH−1). The `o_up`/`o_down` pulse is still emitted when clamped.
  - SATURATE=0: plain modular wrap.
- **`i_clear`:** count goes to 0 and `o_error` to 0 on the next edge. It beats a coincident step: the count becomes 0, not ±1. The step pulse for that cycle is still emitted.
- **Independence:** channels are fully independent. Simultaneous steps on different channels are all honoured.

## Timing
- **Reset values:** `o_up`, `o_down`, `o_count`, `o_error` all 0 after an `i_rst` edge.
- **Step latency:** a pin change first sampled at edge 0 appears at the last synchroniser stage after edge SYNC_STAGES−1. It is accepted at edge SYNC_STAGES−1+DEBOUNCE_CYCLES. `o_up`/`o_down`/`o_count` update on the following edge. Total: SYNC_STAGES+DEBOUNCE_CYCLES edges.
- **Pulse shape:** `o_up`/`o_down` are exactly 1 cycle wide and never both high on one channel.
- **Error flag:** `o_error` rises in the same cycle the step would have been decoded.
- **Bypass:** DEBOUNCE_CYCLES=0 removes the debounce stage entirely; latency is SYNC_STAGES edges.
- **Registered outputs:** all outputs are registered; there are no combinational paths from inputs.

## Structure
- **Shared package/header `rotary_pkg`:**
  - MODE_X1 and MODE_X4 constants.
  - 2-bit state encodings.
  - The 4x transition function (prev state, new state) → {up, down, err}.
- **Sub-module `rotary_encoder_channel`:**
  - Contains synchroniser, debounce, decode and counter for one channel.
  - The top generates CHANNELS instances and packs their outputs.

## Test plan
Bench parameters: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, COUNT_WIDTH=8.
- **1x decode:** MODE=0, ch0 drives one full up cycle then one down cycle, each level held 10 cycles. Required: one `o_up` then one `o_down`; count 0→1→0, with each pulse 6 edges after the A edge.
- **4x decode:** MODE=1, ch1 runs 3 full up cycles. Required: 12 `o_up` pulses, count=12, `o_error`=0, ch0 count stays 0.
- **Debounce:** A toggled with 3-cycle glitches ×5, then held. Required: exactly one step, after the final stable level.
- **Saturation and wrap:** SATURATE=1 with 130 up steps gives count=127 and 130 pulses. SATURATE=0 from 127 with one up step gives count=−128.
- **Illegal transition and clear:** 4x mode, state 00→11. Required: no step and `o_error`=1. Then `i_clear` coincident with an up step gives count=0, `o_error`=0, and one `o_up` pulse.
- **Reset mid-operation:** assert `i_rst` for 3 cycles with pins held at {1,1} and count=5. Required: all outputs 0 and no step pulse after release.

Source files
------------

// File: rtl/rotary_pkg.sv
// Shared definitions for the rotary encoder decoder.
//   MODE_X1 / MODE_X4 : decode-mode selector values for the MODE parameter
//   ab_state_e        : accepted {A,B} pin state encodings
//   step_t            : one decoded step {up, down, err}
//   decode_x4()       : Gray-code transition -> step, 4x mode
//   decode_x1()       : A-rising-edge -> step, 1x mode
package rotary_pkg;

  localparam int MODE_X1 = 0;
  localparam int MODE_X4 = 1;

  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_01 = 2'b01,
    AB_10 = 2'b10,
    AB_11 = 2'b11
  } ab_state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic err;
  } step_t;

  // Position of a state along the up sequence 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      AB_00:   return 2'd0;
      AB_10:   return 2'd1;
      AB_11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // The modulo-4 distance along the up sequence gives the direction:
  // +1 is up, -1 (3) is down, 2 means both pins changed at once.
  function automatic step_t decode_x4(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    step_t      s;
    logic [1:0] delta;
    s     = '0;
    delta = gray_pos(cur_ab) - gray_pos(prev_ab);
    case (delta)
      2'd1:    s.up   = 1'b1;
      2'd3:    s.down = 1'b1;
      2'd2:    s.err  = 1'b1;
      default: s      = '0;
    endcase
    return s;
  endfunction

  // Only a rising A counts; the B level at that moment picks the direction.
  function automatic step_t decode_x1(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
    step_t s;
    logic  a_rise;
    s      = '0;
    a_rise = !prev_ab[1] && cur_ab[1];
    s.up   = a_rise && !cur_ab[0];
    s.down = a_rise && cur_ab[0];
    return s;
  endfunction

endpackage

// File: rtl/rotary_encoder_channel.sv
// One quadrature encoder channel: synchroniser, per-bit debounce, step
// decode and signed position counter.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_a, i_b            : raw asynchronous encoder pins
//   i_clear             : synchronous clear of count and error flag
//   o_up, o_down        : 1-cycle step pulses
//   o_count             : signed position count
//   o_error             : sticky illegal-transition flag (4x mode only)
module rotary_encoder_channel
  import rotary_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COUNT_WIDTH     = 16,
  parameter int MODE            = MODE_X1,
  parameter int SATURATE        = 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_a,
  input  logic                          i_b,
  input  logic                          i_clear,
  output logic                          o_up,
  output logic                          o_down,
  output logic signed [COUNT_WIDTH-1:0] o_count,
  output logic                          o_error
);

  localparam logic signed [COUNT_WIDTH-1:0] CNT_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
  localparam logic signed [COUNT_WIDTH-1:0] CNT_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
  localparam logic signed [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  // One step on the counter, clamping at the signed limits when SATURATE
  // is set and wrapping modulo 2^COUNT_WIDTH otherwise.
  function automatic logic signed [COUNT_WIDTH-1:0] sat_step(
    input logic signed [COUNT_WIDTH-1:0] cur,
    input logic                          up,
    input logic                          down
  );
    logic signed [COUNT_WIDTH-1:0] res;
    res = cur;
    if (up) begin
      if (SATURATE == 0 || cur != CNT_MAX) res = cur + CNT_ONE;
    end else if (down) begin
      if (SATURATE == 0 || cur != CNT_MIN) res = cur - CNT_ONE;
    end
    return res;
  endfunction

  // ---- Stage: synchroniser (bit 1 = A, bit 0 = B; index 0 is newest) ----
  logic [SYNC_STAGES-1:0][1:0] sync_q;
  logic [1:0]                  sync_last;

  always_ff @(posedge i_clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], i_a, i_b};
  end

  assign sync_last = sync_q[SYNC_STAGES-1];

  // ---- Stage: debounce -> accepted {A,B} ----
  logic [1:0] acc_ab;

  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign acc_ab = sync_last;
  end else begin : g_debounce
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]         acc_q, acc_d;
    logic [1:0][CW-1:0] cnt_q, cnt_d;

    // The counter holds the number of consecutive differing samples seen so
    // far; the D-th differing sample is accepted directly instead of being
    // counted, so the counter never needs to represent D itself.
    always_comb begin
      acc_d = acc_q;
      cnt_d = '0;
      for (int i = 0; i < 2; i++) begin
        if (sync_last[i] != acc_q[i]) begin
          if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) acc_d[i] = sync_last[i];
          else                                      cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        acc_q <= sync_last;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_d;
        cnt_q <= cnt_d;
      end
    end

    assign acc_ab = acc_q;
  end

  // ---- Stage: decode and count ----
  logic [1:0]                    prev_q;
  step_t                         step;
  logic                          up_q, down_q, err_q, err_d;
  logic signed [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    step = '0;
    if (MODE == MODE_X4) step = decode_x4(prev_q, acc_ab);
    else                 step = decode_x1(prev_q, acc_ab);

    count_d = sat_step(count_q, step.up, step.down);
    err_d   = err_q | step.err;
    // Clear wins over a coincident step; the step pulse itself still goes out.
    if (i_clear) begin
      count_d = '0;
      err_d   = 1'b0;
    end
  end

  // In reset prev_q tracks the pins as well, so the accepted and previous
  // states agree at release and no phantom step is decoded.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prev_q  <= sync_last;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      prev_q  <= acc_ab;
      up_q    <= step.up;
      down_q  <= step.down;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  assign o_up    = up_q;
  assign o_down  = down_q;
  assign o_error = err_q;
  assign o_count = count_q;

endmodule

// File: rtl/rotary_encoder_array.sv
// Multi-channel quadrature decoder for the front-panel rotary encoders.
// Each channel is fully independent; outputs are packed per channel.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_a, i_b       : raw asynchronous encoder pins, one bit per channel
//   i_clear        : per-channel synchronous clear of count and error
//   o_up, o_down   : per-channel 1-cycle step pulses
//   o_count        : channel n at [n*COUNT_WIDTH +: COUNT_WIDTH], two's complement
//   o_error        : per-channel sticky illegal-transition flag
module rotary_encoder_array
  import rotary_pkg::*;
#(
  parameter int CHANNELS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int COUNT_WIDTH     = 16,
  parameter int MODE            = MODE_X1,
  parameter int SATURATE        = 1
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [CHANNELS-1:0]             i_a,
  input  logic [CHANNELS-1:0]             i_b,
  input  logic [CHANNELS-1:0]             i_clear,
  output logic [CHANNELS-1:0]             o_up,
  output logic [CHANNELS-1:0]             o_down,
  output logic [CHANNELS*COUNT_WIDTH-1:0] o_count,
  output logic [CHANNELS-1:0]             o_error
);

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    logic signed [COUNT_WIDTH-1:0] count;

    rotary_encoder_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .COUNT_WIDTH    (COUNT_WIDTH),
      .MODE           (MODE),
      .SATURATE       (SATURATE)
    ) u_ch (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_a    (i_a[n]),
      .i_b    (i_b[n]),
      .i_clear(i_clear[n]),
      .o_up   (o_up[n]),
      .o_down (o_down[n]),
      .o_count(count),
      .o_error(o_error[n])
    );

    assign o_count[n*COUNT_WIDTH +: COUNT_WIDTH] = count;
  end

endmodule
